nbrs_counter: RTL and testbench

NBRS_COUNTER -- requirements
Module: nbrs_counter

---
 rtl/gol_pkg.sv | 30 +++
 rtl/adr_offset.sv | 64 ++++++
 rtl/nbrs_counter.sv | 187 ++++++++++++++++++
 tb/tb_nbrs_counter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gol_pkg
//  Description : Shared definitions for the neighbourhood counter: FSM state
//                encoding and helpers sizing the neighbour count from the
//                neighbourhood radius.
//  Revision    : 1.0 - initial release
// ============================================================================
package gol_pkg;

    // Explicit 2-bit encoding so the state register width is fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of neighbours in a square neighbourhood, centre excluded.
    function automatic int nbrs_cnt(input int radius);
        return (2 * radius + 1) * (2 * radius + 1) - 1;
    endfunction

    // Counter width able to hold every value 0..nbrs_cnt inclusive.
    function automatic int cnt_size(input int radius);
        return $clog2(nbrs_cnt(radius) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adr_offset.sv
`default_nettype none
// ============================================================================
//  Module      : adr_offset
//  Description : Adds a small signed offset to a field coordinate. Out-of-range
//                results are folded back into 0..SIZE-1 by a single add or
//                subtract of SIZE (the offset magnitude is always below SIZE).
//                With WRAP=1 every result is reported in range; with WRAP=0 a
//                fold marks the position as outside the field.
//  Ports       : i_coord    - coordinate, 0..SIZE-1
//                i_offset   - signed offset, |offset| < SIZE
//                o_coord    - folded coordinate
//                o_in_range - position usable for a read
//  Revision    : 1.0 - initial release
// ============================================================================
module adr_offset #(
    parameter int SIZE  = 30,
    parameter int ADR_W = 5,
    parameter int OFS_W = 3,
    parameter int WRAP  = 0
) (
    input  logic [ADR_W-1:0]        i_coord,
    input  logic signed [OFS_W-1:0] i_offset,
    output logic [ADR_W-1:0]        o_coord,
    output logic                    o_in_range
);

    // Two guard bits: one for sign, one so coord+offset cannot overflow.
    localparam int c_sw = ADR_W + 2;
    localparam logic signed [c_sw-1:0] c_size    = c_sw'(SIZE);
    localparam logic [ADR_W-1:0]       c_size_lo = ADR_W'(SIZE);

    logic signed [c_sw-1:0] w_coord_ext;
    logic signed [c_sw-1:0] w_ofs_ext;
    logic signed [c_sw-1:0] w_sum;
    logic                   w_under;
    logic                   w_over;

    assign w_coord_ext = $signed({2'b00, i_coord});
    assign w_ofs_ext   = c_sw'(i_offset);
    assign w_sum       = w_coord_ext + w_ofs_ext;
    assign w_under     = w_sum[c_sw-1];
    assign w_over      = !w_under && (w_sum >= c_size);

    // Low bits only: adding/subtracting SIZE modulo 2^ADR_W gives the same
    // result in the kept bits as the full-width operation.
    always_comb begin
        o_coord = w_sum[ADR_W-1:0];
        if (w_under) begin
            o_coord = w_sum[ADR_W-1:0] + c_size_lo;
        end else if (w_over) begin
            o_coord = w_sum[ADR_W-1:0] - c_size_lo;
        end
    end

    generate
        if (WRAP != 0) begin : g_wrap
            assign o_in_range = 1'b1;
        end else begin : g_bounded
            assign o_in_range = !(w_under || w_over);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/nbrs_counter.sv
`default_nettype none
// ============================================================================
//  Module      : nbrs_counter
//  Description : Counts live neighbours of one cell by reading the cell memory
//                once per neighbour position in row-major order. Latency is
//                fixed at NBRS_CNT+2 cycles from request accept to result.
//  Ports       : i_clk, i_rst                 - clock, sync active-high reset
//                i_cell_x_adr, i_cell_y_adr   - centre cell
//                i_req_valid / o_req_ready    - request handshake
//                o_rd_x_adr, o_rd_y_adr, o_rd_en - memory read request
//                i_rd_data                    - read data, one cycle after en
//                o_cnt, o_cnt_valid / i_cnt_ready - result handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module nbrs_counter
    import gol_pkg::*;
#(
    parameter int FIELD_W = 30,
    parameter int FIELD_H = 50,
    parameter int RADIUS  = 1,
    parameter int WRAP    = 0,
    localparam int X_ADR_SIZE = $clog2(FIELD_W),
    localparam int Y_ADR_SIZE = $clog2(FIELD_H),
    localparam int NBRS_CNT   = nbrs_cnt(RADIUS),
    localparam int CNT_SIZE   = cnt_size(RADIUS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [X_ADR_SIZE-1:0] i_cell_x_adr,
    input  logic [Y_ADR_SIZE-1:0] i_cell_y_adr,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    output logic [X_ADR_SIZE-1:0] o_rd_x_adr,
    output logic [Y_ADR_SIZE-1:0] o_rd_y_adr,
    output logic                  o_rd_en,
    input  logic                  i_rd_data,
    output logic [CNT_SIZE-1:0]   o_cnt,
    output logic                  o_cnt_valid,
    input  logic                  i_cnt_ready
);

    // Index counters run 0..2R; offset = index - R.
    localparam int c_idx_w = $clog2(2 * RADIUS + 1);
    localparam int c_ofs_w = c_idx_w + 1;
    localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(2 * RADIUS);
    localparam logic [c_idx_w-1:0] c_idx_ctr = c_idx_w'(RADIUS);

    state_t                r_state;
    logic [X_ADR_SIZE-1:0] r_cell_x;
    logic [Y_ADR_SIZE-1:0] r_cell_y;
    logic [c_idx_w-1:0]    r_dx_idx;
    logic [c_idx_w-1:0]    r_dy_idx;
    logic                  r_rd_en_d;
    logic [CNT_SIZE-1:0]   r_acc;
    logic                  r_req_ready;
    logic                  r_cnt_valid;

    logic signed [c_ofs_w-1:0] w_dx;
    logic signed [c_ofs_w-1:0] w_dy;
    logic [X_ADR_SIZE-1:0]     w_x;
    logic [Y_ADR_SIZE-1:0]     w_y;
    logic                      w_x_in;
    logic                      w_y_in;
    logic                      w_rd_en;
    logic [c_idx_w-1:0]        w_nx_idx;
    logic [c_idx_w-1:0]        w_ny_idx;
    logic                      w_last;

    assign w_dx = c_ofs_w'(r_dx_idx) - c_ofs_w'(RADIUS);
    assign w_dy = c_ofs_w'(r_dy_idx) - c_ofs_w'(RADIUS);

    adr_offset #(
        .SIZE  (FIELD_W),
        .ADR_W (X_ADR_SIZE),
        .OFS_W (c_ofs_w),
        .WRAP  (WRAP)
    ) u_x_ofs (
        .i_coord    (r_cell_x),
        .i_offset   (w_dx),
        .o_coord    (w_x),
        .o_in_range (w_x_in)
    );

    adr_offset #(
        .SIZE  (FIELD_H),
        .ADR_W (Y_ADR_SIZE),
        .OFS_W (c_ofs_w),
        .WRAP  (WRAP)
    ) u_y_ofs (
        .i_coord    (r_cell_y),
        .i_offset   (w_dy),
        .o_coord    (w_y),
        .o_in_range (w_y_in)
    );

    // Out-of-field positions still take their SCAN cycle, only the read is
    // suppressed, which keeps latency independent of position.
    assign w_rd_en    = (r_state == ST_SCAN) && w_x_in && w_y_in;
    assign o_rd_en    = w_rd_en;
    assign o_rd_x_adr = w_rd_en ? w_x : '0;
    assign o_rd_y_adr = w_rd_en ? w_y : '0;

    assign o_req_ready = r_req_ready;
    assign o_cnt_valid = r_cnt_valid;
    assign o_cnt       = r_acc;

    // Next neighbour position, row-major, hopping over the centre. The
    // centre is never the last position of a row, so a single extra step
    // after the hop always stays within the row.
    always_comb begin
        w_nx_idx = r_dx_idx + c_idx_w'(1);
        w_ny_idx = r_dy_idx;
        if (r_dx_idx == c_idx_max) begin
            w_nx_idx = '0;
            w_ny_idx = r_dy_idx + c_idx_w'(1);
        end
        if ((w_nx_idx == c_idx_ctr) && (w_ny_idx == c_idx_ctr)) begin
            w_nx_idx = w_nx_idx + c_idx_w'(1);
        end
    end

    assign w_last = (r_dx_idx == c_idx_max) && (r_dy_idx == c_idx_max);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cell_x    <= '0;
            r_cell_y    <= '0;
            r_dx_idx    <= '0;
            r_dy_idx    <= '0;
            r_rd_en_d   <= 1'b0;
            r_acc       <= '0;
            r_req_ready <= 1'b1;
            r_cnt_valid <= 1'b0;
        end else begin
            // Read data is tagged by the enable of the previous cycle, so a
            // suppressed read never contributes.
            r_rd_en_d <= w_rd_en;
            if (r_rd_en_d && i_rd_data) begin
                r_acc <= r_acc + CNT_SIZE'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_cell_x    <= i_cell_x_adr;
                        r_cell_y    <= i_cell_y_adr;
                        r_dx_idx    <= '0;
                        r_dy_idx    <= '0;
                        r_acc       <= '0;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_last) begin
                        r_dx_idx <= '0;
                        r_dy_idx <= '0;
                        r_state  <= ST_DRAIN;
                    end else begin
                        r_dx_idx <= w_nx_idx;
                        r_dy_idx <= w_ny_idx;
                    end
                end
                ST_DRAIN: begin
                    // The final read's data is absorbed on this edge.
                    r_cnt_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_cnt_ready) begin
                        r_cnt_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_cnt_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nbrs_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nbrs_counter
//  Description : Self-checking bench for nbrs_counter. One bounded (WRAP=0)
//                and one toroidal (WRAP=1) instance share a behavioural cell
//                memory. Expected counts and read addresses come from a
//                reference model and are queued when a request is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nbrs_counter;

    localparam int FW = 30;
    localparam int FH = 50;
    localparam int R  = 1;
    localparam int NB = 8;
    localparam int XW = 5;
    localparam int YW = 6;
    localparam int CW = 4;

    typedef struct {
        int x;
        int y;
    } rd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [XW-1:0] cell_x;
    logic [YW-1:0] cell_y;
    logic          cnt_ready;
    logic          req_valid [2];
    logic          req_ready [2];
    logic          rd_en     [2];
    logic          rd_data   [2];
    logic          cnt_valid [2];
    logic [XW-1:0] rd_x      [2];
    logic [YW-1:0] rd_y      [2];
    logic [CW-1:0] cnt       [2];

    bit  mem [FH][FW];
    int  cyc = 0;
    rd_t rd_q [$];
    int  exp_q [$];
    int  n_chk = 0;
    int  n_bad = 0;
    int  act = 0;
    bit  mon_on = 1'b0;
    int  centre_hits = 0;
    int  ccx = 0;
    int  ccy = 0;
    rd_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nbrs_counter #(.FIELD_W(FW), .FIELD_H(FH), .RADIUS(R), .WRAP(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_cell_x_adr(cell_x), .i_cell_y_adr(cell_y),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .o_rd_x_adr(rd_x[0]), .o_rd_y_adr(rd_y[0]), .o_rd_en(rd_en[0]),
        .i_rd_data(rd_data[0]), .o_cnt(cnt[0]), .o_cnt_valid(cnt_valid[0]),
        .i_cnt_ready(cnt_ready)
    );

    nbrs_counter #(.FIELD_W(FW), .FIELD_H(FH), .RADIUS(R), .WRAP(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_cell_x_adr(cell_x), .i_cell_y_adr(cell_y),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .o_rd_x_adr(rd_x[1]), .o_rd_y_adr(rd_y[1]), .o_rd_en(rd_en[1]),
        .i_rd_data(rd_data[1]), .o_cnt(cnt[1]), .o_cnt_valid(cnt_valid[1]),
        .i_cnt_ready(cnt_ready)
    );

    // Cell memory: data one cycle after the enable; junk '1' when not enabled
    // so that counting an unrequested read shows up as a wrong count.
    always @(posedge clk) begin
        rd_data[0] <= rd_en[0] ? mem[rd_y[0]][rd_x[0]] : 1'b1;
        rd_data[1] <= rd_en[1] ? mem[rd_y[1]][rd_x[1]] : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Read-address scoreboard for the active instance.
    always @(negedge clk) begin
        if (mon_on) begin
            if (rd_en[act]) begin
                if (rd_x[act] == ccx && rd_y[act] == ccy) centre_hits++;
                if (rd_q.size() == 0) begin
                    check("rd_extra", rd_en[act], 0);
                end else begin
                    mon_e = rd_q.pop_front();
                    check("rd_x", rd_x[act], mon_e.x);
                    check("rd_y", rd_y[act], mon_e.y);
                end
            end else begin
                check("adr0_x", rd_x[act], 0);
                check("adr0_y", rd_y[act], 0);
            end
        end
    end

    task automatic model(input int w, input int cx, input int cy, output int c);
        int  x;
        int  y;
        rd_t e;
        c = 0;
        for (int dy = -R; dy <= R; dy++) begin
            for (int dx = -R; dx <= R; dx++) begin
                if (dx == 0 && dy == 0) continue;
                x = cx + dx;
                y = cy + dy;
                if (w == 1) begin
                    if (x < 0) x += FW;
                    if (x >= FW) x -= FW;
                    if (y < 0) y += FH;
                    if (y >= FH) y -= FH;
                end else if (x < 0 || x >= FW || y < 0 || y >= FH) begin
                    continue;
                end
                e.x = x;
                e.y = y;
                rd_q.push_back(e);
                c += int'(mem[y][x]);
            end
        end
    endtask

    // Starts and ends on a falling edge with the instance idle. When hold>0
    // the caller has cnt_ready low; it is raised after 'hold' DONE cycles.
    task automatic run_req(input int w, input int cx, input int cy, input int hold,
                           output int t_acc);
        int c;
        int n;
        int e_cnt;
        act = w;
        ccx = cx;
        ccy = cy;
        model(w, cx, cy, c);
        exp_q.push_back(c);
        cell_x = XW'(cx);
        cell_y = YW'(cy);
        req_valid[w] = 1'b1;
        check("req_ready", req_ready[w], 1);
        t_acc = cyc;
        @(negedge clk);
        req_valid[w] = 1'b0;
        check("busy_ready", req_ready[w], 0);
        n = 0;
        while (!cnt_valid[w] && n < 40) begin
            @(negedge clk);
            n++;
        end
        e_cnt = exp_q.pop_front();
        if (!cnt_valid[w]) begin
            check("timeout", cnt_valid[w], 1);
            rd_q.delete();
            cnt_ready = 1'b1;
        end else begin
            check("cnt", cnt[w], e_cnt);
            check("latency", cyc - t_acc, NB + 2);
            check("rd_left", rd_q.size(), 0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", cnt_valid[w], 1);
                check("hold_cnt", cnt[w], e_cnt);
                check("hold_rdy", req_ready[w], 0);
            end
            cnt_ready = 1'b1;
            @(negedge clk);
            check("post_valid", cnt_valid[w], 0);
            check("post_rdy", req_ready[w], 1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        int xs [6] = '{0, 29, 15, 3, 28, 0};
        int ys [6] = '{25, 0, 49, 3, 48, 49};

        rst = 1'b1;
        cell_x = '0;
        cell_y = '0;
        cnt_ready = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        foreach (mem[y, x]) mem[y][x] = 1'b1;

        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check("rst_req_ready", req_ready[w], 1);
            check("rst_rd_en", rd_en[w], 0);
            check("rst_cnt_valid", cnt_valid[w], 0);
            check("rst_cnt", cnt[w], 0);
            check("rst_rd_x", rd_x[w], 0);
            check("rst_rd_y", rd_y[w], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;

        // Corners of the field, all-ones memory.
        run_req(0, 0, 0, 0, t1);
        run_req(1, 0, 0, 0, t1);
        run_req(0, 29, 49, 0, t1);
        run_req(1, 29, 49, 0, t1);

        // Back-to-back requests with cnt_ready held high.
        run_req(1, 5, 7, 0, t1);
        run_req(1, 6, 7, 0, t2);
        check("tput", t2 - t1, NB + 3);

        // Sparse memory around an interior cell; centre must not be read.
        foreach (mem[y, x]) mem[y][x] = 1'b0;
        mem[9][9] = 1'b1;
        mem[11][11] = 1'b1;
        mem[10][10] = 1'b1;
        centre_hits = 0;
        run_req(0, 10, 10, 0, t1);
        check("centre_reads", centre_hits, 0);

        // Random memory: result held while cnt_ready is low.
        foreach (mem[y, x]) mem[y][x] = 1'($urandom_range(0, 1));
        cnt_ready = 1'b0;
        run_req(1, 5, 5, 5, t1);

        for (int i = 0; i < 6; i++) begin
            run_req(i % 2, xs[i], ys[i], 0, t1);
        end

        // Reset in the middle of SCAN (k=3).
        mon_on = 1'b0;
        act = 0;
        cell_x = XW'(10);
        cell_y = YW'(10);
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_rd_en", rd_en[0], 0);
        check("midrst_req_ready", req_ready[0], 1);
        check("midrst_cnt_valid", cnt_valid[0], 0);
        rd_q.delete();
        mon_on = 1'b1;
        run_req(0, 10, 10, 0, t1);
        run_req(0, 0, 0, 0, t1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
